csr_regfile: RTL and testbench

- Machine-mode CSR register file for the single-cycle RV32 core.
- Sits directly downstream of the CSR write-data generator. Consumes the final CSR write value (cgu_csr_wdata), returns the old CSR value for rd, and holds trap state (mstatus/mepc/mcause/mtvec) plus cycle/instret counters.
- Reads are combinational; all state updates occur on the rising clock edge.

---
 rtl/csr_regfile.sv | 189 ++++++++++++++++++
 tb/tb_csr_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file for the single-cycle RV32 core: trap state, misa/mhartid, cycle/instret counters.
// Define CSR_COUNTER_EN to build the 64-bit mcycle/minstret counters; otherwise those addresses read 0 and ignore writes.
module csr_regfile #(
    parameter int                  XLEN           = 32,
    parameter int                  CSR_ADDR_WIDTH = 12,
    parameter logic [XLEN-1:0]     MTVEC_RESET    = 32'h0000_0000,
    parameter logic [XLEN-1:0]     MISA_VALUE     = 32'h4000_0100
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      csr_valid_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    input  logic [XLEN-1:0]           cgu_csr_wdata_i,
    output logic [XLEN-1:0]           csr_rdata_o,
    output logic                      illegal_csr_o,
    input  logic                      instr_retire_i,
    input  logic                      trap_i,
    input  logic [XLEN-1:0]           trap_pc_i,
    input  logic [XLEN-1:0]           trap_cause_i,
    input  logic                      mret_i,
    output logic [XLEN-1:0]           mtvec_o,
    output logic [XLEN-1:0]           mepc_o,
    output logic                      mstatus_mie_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MISA      = 12'h301;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MHARTID   = 12'hF14;

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;

    logic            w_impl;
    logic            w_ro_write;
    logic            w_illegal;
    logic            w_write;
    logic            w_mret;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mcycle_lo;
    logic [XLEN-1:0] w_mcycle_hi;
    logic [XLEN-1:0] w_minstret_lo;
    logic [XLEN-1:0] w_minstret_hi;

    // Counter addresses count as implemented even when the counters are not built.
    always_comb begin
        w_impl = 1'b0;
        case (csr_addr_i)
            A_MSTATUS, A_MISA, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MHARTID: w_impl = 1'b1;
            default: w_impl = 1'b0;
        endcase
    end

    assign w_ro_write = csr_we_i & (csr_addr_i[11:10] == 2'b11);
    assign w_illegal  = csr_valid_i & (~w_impl | w_ro_write);
    assign w_write    = csr_valid_i & csr_we_i & ~w_illegal & ~trap_i;
    assign w_mret     = mret_i & ~trap_i & ~w_write;

    assign w_mstatus = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, r_mpie, 3'b000, r_mie, 3'b000};

    always_comb begin
        w_rdata = '0;
        case (csr_addr_i)
            A_MSTATUS:   w_rdata = w_mstatus;
            A_MISA:      w_rdata = MISA_VALUE;
            A_MTVEC:     w_rdata = r_mtvec;
            A_MSCRATCH:  w_rdata = r_mscratch;
            A_MEPC:      w_rdata = r_mepc;
            A_MCAUSE:    w_rdata = r_mcause;
            A_MCYCLE:    w_rdata = w_mcycle_lo;
            A_MCYCLEH:   w_rdata = w_mcycle_hi;
            A_MINSTRET:  w_rdata = w_minstret_lo;
            A_MINSTRETH: w_rdata = w_minstret_hi;
            default:     w_rdata = '0;
        endcase
    end

    assign csr_rdata_o   = w_rdata;
    assign illegal_csr_o = w_illegal;
    assign mtvec_o       = r_mtvec;
    assign mepc_o        = r_mepc;
    assign mstatus_mie_o = r_mie;

    // Trap beats a CSR write, which beats mret.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mie  <= 1'b0;
            r_mpie <= 1'b0;
        end else if (trap_i) begin
            r_mpie <= r_mie;
            r_mie  <= 1'b0;
        end else if (w_write && csr_addr_i == A_MSTATUS) begin
            r_mie  <= cgu_csr_wdata_i[3];
            r_mpie <= cgu_csr_wdata_i[7];
        end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mepc   <= '0;
            r_mcause <= '0;
        end else if (trap_i) begin
            r_mepc   <= {trap_pc_i[XLEN-1:2], 2'b00};
            r_mcause <= trap_cause_i;
        end else if (w_write) begin
            if (csr_addr_i == A_MEPC) begin
                r_mepc <= {cgu_csr_wdata_i[XLEN-1:2], 2'b00};
            end
            if (csr_addr_i == A_MCAUSE) begin
                r_mcause <= cgu_csr_wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
        end else if (w_write) begin
            if (csr_addr_i == A_MTVEC) begin
                r_mtvec <= {cgu_csr_wdata_i[XLEN-1:2], 2'b00};
            end
            if (csr_addr_i == A_MSCRATCH) begin
                r_mscratch <= cgu_csr_wdata_i;
            end
        end
    end

`ifdef CSR_COUNTER_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    // A write to either half loads that half and suppresses the increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mcycle <= '0;
        end else if (w_write && csr_addr_i == A_MCYCLE) begin
            r_mcycle[31:0] <= cgu_csr_wdata_i;
        end else if (w_write && csr_addr_i == A_MCYCLEH) begin
            r_mcycle[63:32] <= cgu_csr_wdata_i;
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_minstret <= '0;
        end else if (w_write && csr_addr_i == A_MINSTRET) begin
            r_minstret[31:0] <= cgu_csr_wdata_i;
        end else if (w_write && csr_addr_i == A_MINSTRETH) begin
            r_minstret[63:32] <= cgu_csr_wdata_i;
        end else if (instr_retire_i) begin
            r_minstret <= r_minstret + 64'd1;
        end
    end

    assign w_mcycle_lo   = r_mcycle[31:0];
    assign w_mcycle_hi   = r_mcycle[63:32];
    assign w_minstret_lo = r_minstret[31:0];
    assign w_minstret_hi = r_minstret[63:32];
`else
    logic w_unused_retire;

    assign w_unused_retire = instr_retire_i;
    assign w_mcycle_lo     = '0;
    assign w_mcycle_hi     = '0;
    assign w_minstret_lo   = '0;
    assign w_minstret_hi   = '0;
`endif

endmodule

// File: tb/tb_csr_regfile.sv
// Directed testbench for csr_regfile: reset values, write masking, trap/mret, priority, illegal access, counters.
module tb_csr_regfile;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        csr_valid_i;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] cgu_csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        illegal_csr_o;
    logic        instr_retire_i;
    logic        trap_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_cause_i;
    logic        mret_i;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mstatus_mie_o;

    int n_checks = 0;
    int n_fail   = 0;

    csr_regfile dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .csr_valid_i     (csr_valid_i),
        .csr_we_i        (csr_we_i),
        .csr_addr_i      (csr_addr_i),
        .cgu_csr_wdata_i (cgu_csr_wdata_i),
        .csr_rdata_o     (csr_rdata_o),
        .illegal_csr_o   (illegal_csr_o),
        .instr_retire_i  (instr_retire_i),
        .trap_i          (trap_i),
        .trap_pc_i       (trap_pc_i),
        .trap_cause_i    (trap_cause_i),
        .mret_i          (mret_i),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .mstatus_mie_o   (mstatus_mie_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        csr_valid_i     = 1'b0;
        csr_we_i        = 1'b0;
        cgu_csr_wdata_i = '0;
        trap_i          = 1'b0;
        trap_pc_i       = '0;
        trap_cause_i    = '0;
        mret_i          = 1'b0;
        instr_retire_i  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_valid_i = 1'b1;
        csr_we_i    = 1'b0;
        csr_addr_i  = addr;
        #1;
        check(tag, csr_rdata_o, exp);
        csr_valid_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_valid_i     = 1'b1;
        csr_we_i        = 1'b1;
        csr_addr_i      = addr;
        cgu_csr_wdata_i = data;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    task automatic trap(input logic [31:0] pc, input logic [31:0] cause);
        trap_i       = 1'b1;
        trap_pc_i    = pc;
        trap_cause_i = cause;
        @(posedge clk_i);
        #1;
        idle();
    endtask

    initial begin
        rst_n_i    = 1'b0;
        csr_addr_i = 12'h300;
        idle();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_mtvec_o", mtvec_o, 32'h0);
        check("rst_mepc_o", mepc_o, 32'h0);
        check("rst_mie_o", {31'b0, mstatus_mie_o}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        rd_check("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_valid_i = 1'b1;
        #1;
        check("rst_illegal", {31'b0, illegal_csr_o}, 32'h0);
        rd_check("rst_mtvec", 12'h305, 32'h0);
        rd_check("rst_mhartid", 12'hF14, 32'h0);
        rd_check("misa", 12'h301, 32'h4000_0100);

        wr(12'h305, 32'h8000_0103);
        check("mtvec_o", mtvec_o, 32'h8000_0100);
        rd_check("mtvec_rd", 12'h305, 32'h8000_0100);

        wr(12'h300, 32'h0000_0008);
        rd_check("mstatus_mie", 12'h300, 32'h0000_1808);
        check("mie_o_set", {31'b0, mstatus_mie_o}, 32'h1);

        trap(32'h0000_0206, 32'h0000_000B);
        check("trap_mepc_o", mepc_o, 32'h0000_0204);
        rd_check("trap_mepc", 12'h341, 32'h0000_0204);
        rd_check("trap_mcause", 12'h342, 32'h0000_000B);
        rd_check("trap_mstatus", 12'h300, 32'h0000_1880);
        check("trap_mie_o", {31'b0, mstatus_mie_o}, 32'h0);

        mret_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle();
        rd_check("mret_mstatus", 12'h300, 32'h0000_1888);
        check("mret_mie_o", {31'b0, mstatus_mie_o}, 32'h1);

        // trap beats a same-cycle mscratch write
        trap_i          = 1'b1;
        trap_pc_i       = 32'h0000_0100;
        trap_cause_i    = 32'h0000_0003;
        csr_valid_i     = 1'b1;
        csr_we_i        = 1'b1;
        csr_addr_i      = 12'h340;
        cgu_csr_wdata_i = 32'h0000_0055;
        @(posedge clk_i);
        #1;
        idle();
        rd_check("prio_mscratch", 12'h340, 32'h0);
        rd_check("prio_mepc", 12'h341, 32'h0000_0100);
        rd_check("prio_mcause", 12'h342, 32'h0000_0003);
        rd_check("prio_mstatus", 12'h300, 32'h0000_1880);

        // CSR write beats a same-cycle mret
        mret_i = 1'b1;
        wr(12'h340, 32'h0000_0011);
        rd_check("wr_mret_mscratch", 12'h340, 32'h0000_0011);
        rd_check("wr_mret_mstatus", 12'h300, 32'h0000_1880);

        wr(12'h340, 32'hDEAD_BEEF);
        rd_check("mscratch", 12'h340, 32'hDEAD_BEEF);
        wr(12'h341, 32'h0000_1237);
        rd_check("mepc_wr", 12'h341, 32'h0000_1234);
        wr(12'h342, 32'h8000_0007);
        rd_check("mcause_wr", 12'h342, 32'h8000_0007);
        wr(12'h300, 32'hFFFF_FFFF);
        rd_check("mstatus_mask", 12'h300, 32'h0000_1888);

        csr_valid_i = 1'b1;
        csr_addr_i  = 12'h7C0;
        #1;
        check("unimpl_rdata", csr_rdata_o, 32'h0);
        check("unimpl_illegal", {31'b0, illegal_csr_o}, 32'h1);
        csr_valid_i = 1'b0;
        #1;
        check("novalid_illegal", {31'b0, illegal_csr_o}, 32'h0);

        csr_valid_i = 1'b1;
        csr_we_i    = 1'b1;
        csr_addr_i  = 12'hF14;
        cgu_csr_wdata_i = 32'h1234_5678;
        #1;
        check("mhartid_wr_illegal", {31'b0, illegal_csr_o}, 32'h1);
        @(posedge clk_i);
        #1;
        idle();
        rd_check("mhartid_hold", 12'hF14, 32'h0);

        csr_valid_i = 1'b1;
        csr_we_i    = 1'b1;
        csr_addr_i  = 12'h301;
        #1;
        check("misa_wr_legal", {31'b0, illegal_csr_o}, 32'h0);
        idle();
        wr(12'h301, 32'h0);
        rd_check("misa_hold", 12'h301, 32'h4000_0100);

`ifdef CSR_COUNTER_EN
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd_check("mcycle_pre", 12'hB00, 32'hFFFF_FFFF);
        rd_check("mcycleh_pre", 12'hB80, 32'hFFFF_FFFF);
        @(posedge clk_i);
        #1;
        rd_check("mcycle_wrap", 12'hB00, 32'h0);
        rd_check("mcycleh_wrap", 12'hB80, 32'h0);

        wr(12'hB02, 32'h0000_0005);
        instr_retire_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        instr_retire_i = 1'b0;
        rd_check("minstret", 12'hB02, 32'h0000_0008);
        rd_check("minstreth", 12'hB82, 32'h0);
`else
        csr_valid_i = 1'b1;
        csr_we_i    = 1'b1;
        csr_addr_i  = 12'hB00;
        #1;
        check("ctr_off_illegal", {31'b0, illegal_csr_o}, 32'h0);
        idle();
        wr(12'hB00, 32'h0000_1234);
        rd_check("ctr_off_mcycle", 12'hB00, 32'h0);
        instr_retire_i = 1'b1;
        @(posedge clk_i);
        #1;
        instr_retire_i = 1'b0;
        rd_check("ctr_off_minstret", 12'hB02, 32'h0);
`endif

        // asynchronous reset mid-write
        csr_valid_i     = 1'b1;
        csr_we_i        = 1'b1;
        csr_addr_i      = 12'h305;
        cgu_csr_wdata_i = 32'h0000_4444;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_mtvec_o", mtvec_o, 32'h0);
        check("async_mepc_o", mepc_o, 32'h0);
        check("async_mie_o", {31'b0, mstatus_mie_o}, 32'h0);
        idle();
        rd_check("async_mstatus", 12'h300, 32'h0000_1800);
        rd_check("async_mscratch", 12'h340, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
